hamming74_decoder: RTL and testbench

Pipelined Hamming (7,4) single-error-correcting decoder. It is the receive-side counterpart of the team's Hamming (7,4) encoder. It accepts 7-bit codewords in the encoder's bit layout over a valid/ready stream. It returns the corrected 4-bit data word, a per-word correction flag and the syndrome, and keeps a saturating count of corrected words for link-quality monitoring.

---
 rtl/hamming74_pkg.sv | 26 ++
 rtl/hamming74_syndrome.sv | 11 +
 rtl/hamming74_decoder.sv | 92 +++++++++
 tb/tb_hamming74_decoder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming74_pkg.sv
// rtl/hamming74_pkg.sv - shared Hamming (7,4) widths, bit positions and syndrome function
package hamming74_pkg;

  localparam int CODE_W = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  // Hamming position p (1..7) lives at codeword bit index POS_BASE - p
  localparam logic [SYN_W-1:0] POS_BASE = 3'd7;

  // Data bit indices inside the {p1,p2,d3,p3,d2,d1,d0} layout
  localparam int IDX_D3 = 4;
  localparam int IDX_D2 = 2;
  localparam int IDX_D1 = 1;
  localparam int IDX_D0 = 0;

  // Returns {s3,s2,s1}; its value is the Hamming position of a single flipped bit
  function automatic logic [SYN_W-1:0] syndrome(input logic [CODE_W-1:0] c);
    logic s1, s2, s3;
    s1 = c[6] ^ c[4] ^ c[2] ^ c[0];
    s2 = c[5] ^ c[4] ^ c[1] ^ c[0];
    s3 = c[3] ^ c[2] ^ c[1] ^ c[0];
    return {s3, s2, s1};
  endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// rtl/hamming74_syndrome.sv - combinational Hamming (7,4) syndrome generator
module hamming74_syndrome
  import hamming74_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syn
);

  assign syn = syndrome(code);

endmodule

// File: rtl/hamming74_decoder.sv
// rtl/hamming74_decoder.sv - two-stage pipelined Hamming (7,4) decoder with correction counter
module hamming74_decoder
  import hamming74_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_corrected,
  output logic [SYN_W-1:0]  syndrome_out,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  corr_count
);

  logic              stall;
  logic [SYN_W-1:0]  syn_in;
  logic [CODE_W-1:0] code1;
  logic [SYN_W-1:0]  syn1;
  logic              v1;
  logic [CODE_W-1:0] fixed;
  logic [SYN_W-1:0]  flip_idx;
  logic [DATA_W-1:0] data_fixed;

  // Whole pipeline freezes while the output word is held by downstream
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  hamming74_syndrome u_syndrome (
    .code (code_in),
    .syn  (syn_in)
  );

  // S1: capture codeword and its syndrome; bubbles pass as v1=0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1    <= 1'b0;
      code1 <= '0;
      syn1  <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      if (in_valid) begin
        code1 <= code_in;
        syn1  <= syn_in;
      end
    end
  end

  // Flip the bit the syndrome points at, then pull out the data bits
  always_comb begin
    fixed    = code1;
    flip_idx = POS_BASE - syn1;
    if (syn1 != '0) begin
      fixed[flip_idx] = ~code1[flip_idx];
    end
    data_fixed = {fixed[IDX_D3], fixed[IDX_D2], fixed[IDX_D1], fixed[IDX_D0]};
  end

  // S2: register corrected word; fields hold their last value on bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      data_out      <= '0;
      err_corrected <= 1'b0;
      syndrome_out  <= '0;
    end else if (!stall) begin
      out_valid <= v1;
      if (v1) begin
        data_out      <= data_fixed;
        err_corrected <= (syn1 != '0);
        syndrome_out  <= syn1;
      end
    end
  end

  // Saturating count of delivered corrected words; clear wins over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      corr_count <= '0;
    end else if (cnt_clear) begin
      corr_count <= '0;
    end else if (out_valid && out_ready && err_corrected && (corr_count != '1)) begin
      corr_count <= corr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming74_decoder.sv
// tb/tb_hamming74_decoder.sv - randomized self-checking bench for hamming74_decoder
module tb_hamming74_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  code_in = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic        cnt_clear = 1'b0;

  logic        in_ready, err_corrected, out_valid;
  logic [3:0]  data_out;
  logic [2:0]  syndrome_out;
  logic [15:0] corr_count;

  logic        in_ready_s, err_corrected_s, out_valid_s;
  logic [3:0]  data_out_s;
  logic [2:0]  syndrome_out_s;
  logic [3:0]  corr_count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming74_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .err_corrected(err_corrected), .syndrome_out(syndrome_out),
    .out_valid(out_valid), .out_ready(out_ready), .cnt_clear(cnt_clear), .corr_count(corr_count)
  );

  hamming74_decoder #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .code_in(code_in), .in_valid(in_valid), .in_ready(in_ready_s),
    .data_out(data_out_s), .err_corrected(err_corrected_s), .syndrome_out(syndrome_out_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .cnt_clear(cnt_clear), .corr_count(corr_count_s)
  );

  // Encoder layout {p1,p2,d3,p3,d2,d1,d0}; each parity covers its Hamming-position group
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[3] ^ d[2] ^ d[0];
    p2 = d[3] ^ d[1] ^ d[0];
    p3 = d[2] ^ d[1] ^ d[0];
    return {p1, p2, d[3], p3, d[2], d[1], d[0]};
  endfunction

  // Nearest-codeword decode: the (7,4) code is perfect, so one codeword is within distance 1
  function automatic void ref_decode(input logic [6:0] c, output logic [3:0] d, output logic [2:0] pos);
    logic [6:0] diff;
    d = '0;
    pos = '0;
    for (int k = 0; k < 16; k++) begin
      diff = c ^ enc(4'(k));
      if ($countones(diff) <= 1) begin
        d = 4'(k);
        pos = '0;
        for (int i = 0; i < 7; i++) if (diff[i]) pos = 3'(7 - i);
      end
    end
  endfunction

  function automatic logic [6:0] rand_word();
    int f;
    f = int'($urandom_range(0, 7));
    return enc(4'($urandom_range(0, 15))) ^ ((f < 7) ? (7'd1 << f) : 7'd0);
  endfunction

  task automatic clear_counter();
    @(posedge clk); #1;
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
    checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL reset_data got %0h exp 0", data_out); end
    checks++; if (err_corrected !== 1'b0) begin errors++; $display("FAIL reset_err got %0h exp 0", err_corrected); end
    checks++; if (syndrome_out !== 3'd0) begin errors++; $display("FAIL reset_syn got %0h exp 0", syndrome_out); end
    checks++; if (corr_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0h exp 0", corr_count); end
    rst = 1'b1;
  endtask

  task automatic test_clean();
    logic [6:0] codes [3];
    logic [3:0] datas [3];
    codes = '{7'h33, 7'h00, 7'h7F};
    datas = '{4'hB, 4'h0, 4'hF};
    out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      if (t < 3) begin
        in_valid = 1'b1;
        code_in = codes[t];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== (t >= 2)) begin errors++; $display("FAIL clean_latency t=%0d got %0h exp %0h", t, out_valid, (t >= 2)); end
      if (t >= 2) begin
        checks++; if (data_out !== datas[t-2]) begin errors++; $display("FAIL clean_data got %0h exp %0h", data_out, datas[t-2]); end
        checks++; if (err_corrected !== 1'b0) begin errors++; $display("FAIL clean_err got %0h exp 0", err_corrected); end
        checks++; if (syndrome_out !== 3'd0) begin errors++; $display("FAIL clean_syn got %0h exp 0", syndrome_out); end
      end
    end
    @(posedge clk); #1;
    checks++; if (corr_count !== 16'd0) begin errors++; $display("FAIL clean_count got %0h exp 0", corr_count); end
  endtask

  task automatic test_single_sweep();
    logic [6:0] words [$];
    logic [3:0] ed [$];
    logic [2:0] es [$];
    int sent, got, cyc, n;
    words = {7'h23, 7'h73};
    ed = {4'hB, 4'hB};
    es = {3'd3, 3'd1};
    for (int d = 0; d < 16; d++) begin
      for (int i = 0; i < 7; i++) begin
        words.push_back(enc(4'(d)) ^ (7'd1 << i));
        ed.push_back(4'(d));
        es.push_back(3'(7 - i));
      end
    end
    n = words.size();
    clear_counter();
    out_ready = 1'b1;
    sent = 0; got = 0; cyc = 0;
    while (got < n && cyc < n + 20) begin
      @(posedge clk); #1;
      in_valid = (sent < n);
      code_in = (sent < n) ? words[sent] : 7'h00;
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++; if (data_out !== ed[got]) begin errors++; $display("FAIL sweep_data #%0d got %0h exp %0h", got, data_out, ed[got]); end
        checks++; if (syndrome_out !== es[got]) begin errors++; $display("FAIL sweep_syn #%0d got %0h exp %0h", got, syndrome_out, es[got]); end
        checks++; if (err_corrected !== 1'b1) begin errors++; $display("FAIL sweep_err #%0d got %0h exp 1", got, err_corrected); end
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    checks++; if (got != n) begin errors++; $display("FAIL sweep_timeout got %0d exp %0d", got, n); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (corr_count !== 16'(n)) begin errors++; $display("FAIL sweep_count got %0d exp %0d", corr_count, n); end
    checks++; if (corr_count_s !== 4'hF) begin errors++; $display("FAIL sat_count got %0d exp 15", corr_count_s); end
  endtask

  task automatic test_counter();
    int cyc, sent, got;
    out_ready = 1'b1;
    cyc = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    code_in = 7'h23;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_timeout got %0h exp 1", out_valid); end
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    checks++; if (corr_count !== 16'd0) begin errors++; $display("FAIL clr_priority got %0d exp 0", corr_count); end
    checks++; if (corr_count_s !== 4'd0) begin errors++; $display("FAIL clr_priority_small got %0d exp 0", corr_count_s); end
    sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 60) begin
      @(posedge clk); #1;
      in_valid = (sent < 20);
      code_in = enc(4'(sent)) ^ 7'h08;
      @(negedge clk);
      if (out_valid && out_ready) got++;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (corr_count_s !== 4'hF) begin errors++; $display("FAIL sat_hold got %0d exp 15", corr_count_s); end
    checks++; if (corr_count !== 16'd20) begin errors++; $display("FAIL count20 got %0d exp 20", corr_count); end
  endtask

  task automatic test_back_to_back();
    logic [6:0] words [5];
    logic [3:0] qd [$];
    logic [2:0] qs [$];
    logic [3:0] d, hd;
    logic [2:0] s, hs;
    logic he, stalled_prev;
    int sent, got, cyc;
    for (int i = 0; i < 5; i++) words[i] = rand_word();
    sent = 0; got = 0; cyc = 0; stalled_prev = 1'b0;
    hd = '0; hs = '0; he = 1'b0;
    while (got < 5 && cyc < 40) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= 3 && cyc < 6);
      in_valid = (sent < 5);
      code_in = (sent < 5) ? words[sent] : 7'h00;
      @(negedge clk);
      if (out_valid && !out_ready) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0h exp 0", in_ready); end
        if (stalled_prev) begin
          checks++;
          if ({data_out, syndrome_out, err_corrected} !== {hd, hs, he}) begin
            errors++; $display("FAIL stall_stable got %0h exp %0h", {data_out, syndrome_out, err_corrected}, {hd, hs, he});
          end
        end
        hd = data_out; hs = syndrome_out; he = err_corrected; stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (qd.size() == 0) begin
          errors++; $display("FAIL b2b_extra got %0h exp none", data_out);
        end else begin
          d = qd.pop_front(); s = qs.pop_front();
          if ({data_out, syndrome_out, err_corrected} !== {d, s, (s != 3'd0)}) begin
            errors++; $display("FAIL b2b_word got %0h exp %0h", {data_out, syndrome_out, err_corrected}, {d, s, (s != 3'd0)});
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        ref_decode(code_in, d, s);
        qd.push_back(d); qs.push_back(s);
        sent++;
      end
      cyc++;
    end
    checks++; if (got != 5 || qd.size() != 0) begin errors++; $display("FAIL b2b_count got %0d exp 5", got); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [6:0] word;
    logic [3:0] qd [$];
    logic [2:0] qs [$];
    logic [3:0] d;
    logic [2:0] s;
    int sent, got, cyc, ecnt, n;
    n = 200;
    clear_counter();
    sent = 0; got = 0; cyc = 0; ecnt = 0;
    word = $urandom_range(0, 127);
    while (got < n && cyc < 4000) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid = (sent < n) && ($urandom_range(0, 3) != 0);
      code_in = word;
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (qd.size() == 0) begin
          errors++; $display("FAIL rand_extra got %0h exp none", data_out);
        end else begin
          d = qd.pop_front(); s = qs.pop_front();
          if (s != 3'd0) ecnt++;
          if ({data_out, syndrome_out, err_corrected} !== {d, s, (s != 3'd0)}) begin
            errors++; $display("FAIL rand_word #%0d got %0h exp %0h", got, {data_out, syndrome_out, err_corrected}, {d, s, (s != 3'd0)});
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        ref_decode(word, d, s);
        qd.push_back(d); qs.push_back(s);
        sent++;
        word = $urandom_range(0, 127);
      end
      cyc++;
    end
    checks++; if (got != n) begin errors++; $display("FAIL rand_timeout got %0d exp %0d", got, n); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (corr_count !== 16'(ecnt)) begin errors++; $display("FAIL rand_count got %0d exp %0d", corr_count, ecnt); end
    checks++; if (corr_count_s !== 4'((ecnt > 15) ? 15 : ecnt)) begin errors++; $display("FAIL rand_count_small got %0d exp %0d", corr_count_s, (ecnt > 15) ? 15 : ecnt); end
  endtask

  task automatic test_reset_midstream();
    int bad;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    code_in = enc(4'h5) ^ 7'h01;
    @(posedge clk); #1;
    code_in = enc(4'hA) ^ 7'h40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %0h exp 1", out_valid); end
    #1 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %0h exp 0", out_valid); end
    checks++; if (corr_count !== 16'd0) begin errors++; $display("FAIL async_count got %0d exp 0", corr_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL async_in_ready got %0h exp 1", in_ready); end
    checks++; if (data_out !== 4'h0) begin errors++; $display("FAIL async_data got %0h exp 0", data_out); end
    @(posedge clk); #1;
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stale_after_reset got %0d exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_sweep();
    test_counter();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
